// File: rtl/fifo_wr_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_if
// Purpose  : Bundle of the two requester write ports, the FIFO write port and
//            the arbiter status outputs.
//            master : requester/FIFO side (drives req/last/data/fifo_full)
//            slave  : arbiter side (drives acks, FIFO write and status)
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8
);

   // Requester 0
   logic                  req0;
   logic                  last0;
   logic [DATA_WIDTH-1:0] data0;
   logic                  ack0;

   // Requester 1
   logic                  req1;
   logic                  last1;
   logic [DATA_WIDTH-1:0] data1;
   logic                  ack1;

   // FIFO write side
   logic                  fifo_wr;
   logic [DATA_WIDTH-1:0] fifo_wdata;
   logic                  fifo_full;

   // Status
   logic                  busy;
   logic                  timeout_err;

   modport master (
      output req0, last0, data0,
      output req1, last1, data1,
      output fifo_full,
      input  ack0, ack1,
      input  fifo_wr, fifo_wdata,
      input  busy, timeout_err
   );

   modport slave (
      input  req0, last0, data0,
      input  req1, last1, data1,
      input  fifo_full,
      output ack0, ack1,
      output fifo_wr, fifo_wdata,
      output busy, timeout_err
   );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Two-port packet arbiter feeding a single FIFO write port.
//            A grant is held for a whole packet (until an accepted word with
//            last=1) so packets never interleave. Ties from IDLE go to the
//            port not granted most recently. A granted port that stays idle
//            for TIMEOUT consecutive cycles loses its grant and timeout_err
//            pulses for one cycle.
//            Optional macro FIFO_ARB_CNT_EN adds per-port completed-packet
//            counters pkt_cnt0/pkt_cnt1.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  wire logic        clk,
   input  wire logic        reset,
   fifo_wr_arbiter_if.slave bus
`ifdef FIFO_ARB_CNT_EN
   ,
   output logic [7:0]       pkt_cnt0,
   output logic [7:0]       pkt_cnt1
`endif
);

   // -------------------------------------------------------------------------
   // Types and constants
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   // The idle counter fires on the cycle that would bring it to TIMEOUT,
   // so the grant is dropped after exactly TIMEOUT idle cycles.
   localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

   // -------------------------------------------------------------------------
   // Signals
   // -------------------------------------------------------------------------
   state_t                state;
   state_t                state_nxt;
   logic [7:0]            idle_cnt;
   logic [7:0]            idle_cnt_nxt;
   logic                  last_grant;      // index of port granted most recently
   logic                  last_grant_nxt;
   logic                  timeout_fire;
   logic                  timeout_err_q;
   logic                  ack0_c;
   logic                  ack1_c;
   logic [DATA_WIDTH-1:0] wdata_c;

   // -------------------------------------------------------------------------
   // State register: asynchronous reset parks the FSM in IDLE, which by
   // itself forces every combinational output to zero.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next state, acks, write data mux, idle counter and fairness bookkeeping
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      idle_cnt_nxt   = idle_cnt;
      last_grant_nxt = last_grant;
      timeout_fire   = 1'b0;
      ack0_c         = 1'b0;
      ack1_c         = 1'b0;
      wdata_c        = '0;

      case (state)
         IDLE: begin
            idle_cnt_nxt = '0;
            if (bus.req0 && bus.req1) begin
               // Tie: favour the port that was not served last.
               state_nxt = last_grant ? GRANT0 : GRANT1;
            end else if (bus.req0) begin
               state_nxt = GRANT0;
            end else if (bus.req1) begin
               state_nxt = GRANT1;
            end
         end

         GRANT0: begin
            ack0_c  = bus.req0 && !bus.fifo_full;
            wdata_c = bus.data0;
            if (bus.req0) begin
               // A full-FIFO stall with req held is not idleness.
               idle_cnt_nxt = '0;
               if (ack0_c && bus.last0) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = 1'b0;
               end
            end else if (idle_cnt == IDLE_LIMIT) begin
               timeout_fire   = 1'b1;
               idle_cnt_nxt   = '0;
               state_nxt      = IDLE;
               last_grant_nxt = 1'b0;
            end else begin
               idle_cnt_nxt = idle_cnt + 8'd1;
            end
         end

         GRANT1: begin
            ack1_c  = bus.req1 && !bus.fifo_full;
            wdata_c = bus.data1;
            if (bus.req1) begin
               idle_cnt_nxt = '0;
               if (ack1_c && bus.last1) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = 1'b1;
               end
            end else if (idle_cnt == IDLE_LIMIT) begin
               timeout_fire   = 1'b1;
               idle_cnt_nxt   = '0;
               state_nxt      = IDLE;
               last_grant_nxt = 1'b1;
            end else begin
               idle_cnt_nxt = idle_cnt + 8'd1;
            end
         end

         default: begin
            state_nxt    = IDLE;
            idle_cnt_nxt = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Idle counter, most-recent-grant record and registered timeout pulse.
   // Port 1 is recorded as last granted out of reset so port 0 wins the
   // first tie.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt      <= '0;
         last_grant    <= 1'b1;
         timeout_err_q <= 1'b0;
      end else begin
         idle_cnt      <= idle_cnt_nxt;
         last_grant    <= last_grant_nxt;
         timeout_err_q <= timeout_fire;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.ack0        = ack0_c;
   assign bus.ack1        = ack1_c;
   assign bus.fifo_wr     = ack0_c | ack1_c;
   assign bus.fifo_wdata  = wdata_c;
   assign bus.busy        = (state != IDLE);
   assign bus.timeout_err = timeout_err_q;

`ifdef FIFO_ARB_CNT_EN
   // -------------------------------------------------------------------------
   // Completed-packet counters: only an accepted last word counts, so a
   // timed-out packet never increments. Natural 8-bit wrap.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pkt_cnt0 <= 8'd0;
         pkt_cnt1 <= 8'd0;
      end else begin
         if (ack0_c && bus.last0) begin
            pkt_cnt0 <= pkt_cnt0 + 8'd1;
         end
         if (ack1_c && bus.last1) begin
            pkt_cnt1 <= pkt_cnt1 + 8'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed bench for fifo_wr_arbiter. Stimulus pushes the words it
//            expects to see written; an independent monitor pops and compares
//            on every FIFO write. Inputs change 1ns after the rising edge,
//            outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

   localparam int DW     = 8;
   localparam int BUDGET = 40;

   logic clk;
   logic reset;

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_ARB_CNT_EN
   logic [7:0] pkt_cnt0;
   logic [7:0] pkt_cnt1;
`endif

   fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .TIMEOUT    (15)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef FIFO_ARB_CNT_EN
      ,
      .pkt_cnt0 (pkt_cnt0),
      .pkt_cnt1 (pkt_cnt1)
`endif
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           tout_pulses = 0;
   logic [DW-1:0] exp_q[$];

   // Generic comparison
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Set one requester's inputs
   task automatic drive(input bit p, input logic rq, input logic lst, input logic [DW-1:0] d);
      if (p) begin
         bus.req1 = rq; bus.last1 = lst; bus.data1 = d;
      end else begin
         bus.req0 = rq; bus.last0 = lst; bus.data0 = d;
      end
   endtask

   // Send an n-word (1 or 2) packet; returns how many falling edges it took
   // to see the first ack. Called and returns 1ns after a rising edge.
   task automatic send(input bit p, input int n, input logic [DW-1:0] w0,
                       input logic [DW-1:0] w1, output int first_lat);
      logic [DW-1:0] w;
      int            k;
      bit            got;
      first_lat = -1;
      for (int i = 0; i < n; i++) begin
         w = (i == 0) ? w0 : w1;
         drive(p, 1'b1, (i == n - 1), w);
         k   = 0;
         got = 0;
         while (!got && k < BUDGET) begin
            @(negedge clk);
            k++;
            if (p ? bus.ack1 : bus.ack0) got = 1;
         end
         if (i == 0) first_lat = k;
         if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_wait port%0d word%0d: no ack in %0d cycles, expected ack=1", p, i, k);
         end
         @(posedge clk); #1;
      end
      drive(p, 1'b0, 1'b0, '0);
   endtask

   // Reset pulse with immediate output check
   task automatic reset_dut();
      drive(0, 1'b0, 1'b0, '0);
      drive(1, 1'b0, 1'b0, '0);
      bus.fifo_full = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_busy",  bus.busy,        0);
      chk("rst_wr",    bus.fifo_wr,     0);
      chk("rst_terr",  bus.timeout_err, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Monitor / scoreboard
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (bus.timeout_err === 1'b1) tout_pulses++;
         if (bus.fifo_wr === 1'b1) begin
            chk("wr_while_full", bus.fifo_full, 0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got data 0x%0h, expected no write", bus.fifo_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("wdata", bus.fifo_wdata, e);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int l0, l1, tp;

      reset = 1'b0;
      bus.fifo_full = 1'b0;
      drive(0, 1'b0, 1'b0, '0);
      drive(1, 1'b0, 1'b0, '0);
      #2;
      chk("init_busy",  bus.busy,        0);
      chk("init_ack0",  bus.ack0,        0);
      chk("init_ack1",  bus.ack1,        0);
      chk("init_wr",    bus.fifo_wr,     0);
      chk("init_wdata", bus.fifo_wdata,  0);
      chk("init_terr",  bus.timeout_err, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Single packet AA,55 on port 0
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      send(0, 2, 8'hAA, 8'h55, l0);
      chk("single_lat", l0, 2);
      @(negedge clk);
      chk("single_busy_after", bus.busy, 0);
      @(posedge clk); #1;

      // Contention from reset: port 0 packet then port 1 packet
      reset_dut();
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h21);
      fork
         send(0, 2, 8'h10, 8'h11, l0);
         send(1, 2, 8'h20, 8'h21, l1);
      join
      chk("cont_lat0", l0, 2);
      chk("cont_lat1", l1, 5);

      // Full stall for 5 cycles mid-packet
      tp = tout_pulses;
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h32);
      fork
         send(0, 2, 8'h31, 8'h32, l0);
         begin
            repeat (2) @(posedge clk);
            #1 bus.fifo_full = 1'b1;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("stall_ack0", bus.ack0,        0);
               chk("stall_wr",   bus.fifo_wr,     0);
               chk("stall_busy", bus.busy,        1);
               chk("stall_terr", bus.timeout_err, 0);
            end
            @(posedge clk);
            #1 bus.fifo_full = 1'b0;
         end
      join
      chk("stall_no_timeout", tout_pulses, tp);

      // Timeout on port 1 with port 0 pending
      tp = tout_pulses;
      exp_q.push_back(8'h41);
      drive(1, 1'b1, 1'b0, 8'h41);
      @(negedge clk);
      chk("to_lat_idle", bus.ack1, 0);
      @(negedge clk);
      chk("to_ack1", bus.ack1, 1);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, '0);
      exp_q.push_back(8'h51);
      drive(0, 1'b1, 1'b1, 8'h51);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("to_wait_busy", bus.busy,        1);
         chk("to_wait_terr", bus.timeout_err, 0);
         chk("to_wait_ack0", bus.ack0,        0);
      end
      @(negedge clk);
      chk("to_pulse",      bus.timeout_err, 1);
      chk("to_idle_busy",  bus.busy,        0);
      @(negedge clk);
      chk("to_pulse_end",  bus.timeout_err, 0);
      chk("to_grant0_ack", bus.ack0,        1);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("to_done_busy",  bus.busy, 0);
      chk("to_pulse_count", tout_pulses, tp + 1);
      @(posedge clk); #1;

      // Reset mid-packet on port 1
      exp_q.push_back(8'h61);
      drive(1, 1'b1, 1'b0, 8'h61);
      @(negedge clk);
      chk("rm_lat_idle", bus.ack1, 0);
      @(negedge clk);
      chk("rm_ack1", bus.ack1, 1);
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b1, 8'h62);
      #1;
      chk("rm_pre_wr", bus.fifo_wr, 1);
      reset = 1'b0;
      #1;
      chk("rm_ack1",  bus.ack1,        0);
      chk("rm_wr",    bus.fifo_wr,     0);
      chk("rm_wdata", bus.fifo_wdata,  0);
      chk("rm_busy",  bus.busy,        0);
      chk("rm_terr",  bus.timeout_err, 0);
      drive(1, 1'b0, 1'b0, '0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      exp_q.push_back(8'h70);
      exp_q.push_back(8'h80);
      fork
         send(0, 1, 8'h70, 8'h00, l0);
         send(1, 1, 8'h80, 8'h00, l1);
      join
      chk("rm_prio_lat0", l0, 2);
      chk("rm_prio_lat1", l1, 4);

`ifdef FIFO_ARB_CNT_EN
      // 256 one-word packets on port 0: counter wraps to 0
      reset_dut();
      chk("cnt_rst0", pkt_cnt0, 0);
      for (int i = 0; i < 256; i++) begin
         logic [DW-1:0] d;
         d = DW'(i);
         exp_q.push_back(d);
         send(0, 1, d, 8'h00, l0);
         if (i == 0) chk("cnt_first", pkt_cnt0, 1);
      end
      chk("cnt_wrap0", pkt_cnt0, 0);
      chk("cnt_port1", pkt_cnt1, 0);
`endif

      repeat (3) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the word width of every data port.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the number of consecutive idle cycles (range 1-255) allowed inside a granted packet.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning an asynchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have ports req0/req1, input, 1, meaning requester n has a word on datan.
REQ-006 The block SHALL have ports last0/last1, input, 1, meaning the word on datan is the final word of its packet.
REQ-007 The block SHALL have ports data0/data1, input, DATA_WIDTH, meaning the requester write data.
REQ-008 The block SHALL have ports ack0/ack1, output, 1, meaning the word on datan is accepted in this cycle.
REQ-009 The block SHALL have port fifo_wr, output, 1, meaning the FIFO write strobe.
REQ-010 The block SHALL have port fifo_wdata, output, DATA_WIDTH, meaning the FIFO write data.
REQ-011 The block SHALL have port fifo_full, input, 1, meaning the FIFO full flag.
REQ-012 The block SHALL have port busy, output, 1, meaning a packet grant is held.
REQ-013 The block SHALL have port timeout_err, output, 1, meaning a one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT0, GRANT1; busy SHALL be 1 exactly when the state is not IDLE.
REQ-015 In IDLE, if exactly one reqn=1, the next state SHALL be GRANTn; if both are 1, the grant SHALL go to the port not granted most recently (port 0 after reset); if neither is 1, the state SHALL remain IDLE.
REQ-016 In IDLE, ack0, ack1 and fifo_wr SHALL be 0, giving a one-cycle grant latency from the first req to the first possible ack.
REQ-017 In GRANTn, ackn SHALL equal reqn AND NOT fifo_full (combinational), and the other port's ack SHALL be 0.
REQ-018 fifo_wr SHALL equal ack0 OR ack1, and fifo_wdata SHALL equal datan of the granted port (0 in IDLE); write throughput SHALL be one word per cycle while granted.
REQ-019 In GRANTn, ackn=1 with lastn=1 SHALL return the FSM to IDLE and record n as most recently granted.
REQ-020 While the FSM is in GRANTn, the other port's req SHALL be ignored, so packets are never interleaved in the FIFO.
REQ-021 The idle counter SHALL increment each GRANTn cycle with reqn=0 and clear when reqn=1 or in IDLE; fifo_full stalls with reqn=1 SHALL NOT count.
REQ-022 When the idle counter reaches TIMEOUT, the FSM SHALL go to IDLE, record n as most recently granted, and pulse timeout_err (registered) for exactly one cycle; words already written SHALL stay in the FIFO.
REQ-023 fifo_wr SHALL never be 1 while fifo_full=1.

Reset
REQ-024 reset=0 SHALL immediately force the state to IDLE, clear the idle counter, set port 1 as most recently granted, and drive timeout_err=0 and busy=0.
REQ-025 reset=0 SHALL force ack0=0, ack1=0, fifo_wr=0 and fifo_wdata=0; a packet in progress is abandoned without any further write.

Configuration
REQ-026 With macro FIFO_ARB_CNT_EN defined, the block SHALL add outputs pkt_cnt0/pkt_cnt1 (8 bits) counting completed packets per port (ack with last=1), wrapping 255->0, reset to 0, and excluding timed-out packets.
REQ-027 Without FIFO_ARB_CNT_EN, those ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Single packet: req0=1 with data 0xAA, then 0x55 with last0=1, fifo_full=0 -> fifo_wr high for 2 cycles starting 1 cycle after req0 rises, fifo_wdata 0xAA then 0x55, then busy=0.
REQ-029 Contention: req0=req1=1 from reset, each a 2-word packet -> port 0's packet is written first, then port 1's, with no interleaving.
REQ-030 Full stall: fifo_full=1 mid-packet for 5 cycles -> ack and fifo_wr are 0 during the stall, no timeout_err, and writing resumes when full drops.
REQ-031 Timeout: port 1 granted, then req1=0 for 15 cycles -> timeout_err pulses once, the FSM returns to IDLE, and a pending req0 is granted next.
REQ-032 Reset mid-packet: reset=0 after the first word -> all outputs go to 0 immediately, and the next packet from either port restarts from IDLE with port 0 priority.
REQ-033 Counters (FIFO_ARB_CNT_EN): 256 one-word packets on port 0 -> pkt_cnt0 returns to 0 and pkt_cnt1 stays 0.
